// File: rtl/hlsm_counter_gen.sv
// Go/count/done high-level state machine counter: counts up to, or down from, a captured limit in STEP increments.
// Optional feature macro: HLSM_PAUSE_EN adds a pause input that freezes the count while in COUNT.
module hlsm_counter_gen #(
    parameter int WIDTH = 5,
    parameter int STEP  = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             go,
    input  logic [WIDTH-1:0] limit,
    input  logic             down,
    input  logic             abort,
`ifdef HLSM_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dn_q, dn_d;
    logic [WIDTH:0]   up_sum;
    logic             up_hit, dn_hit, hold;

    // One extra bit keeps the up-mode sum from wrapping when lim_q is all ones.
    assign up_sum = {1'b0, count} + STEP_X;
    assign up_hit = (up_sum >= {1'b0, lim_q});
    assign dn_hit = ({1'b0, count} <= STEP_X);

`ifdef HLSM_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        count_d = count;
        lim_d   = lim_q;
        dn_d    = dn_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    lim_d = limit;
                    dn_d  = down;
                    if (limit == '0) begin
                        state_d = S_DONE;
                        count_d = '0;
                    end else begin
                        state_d = S_COUNT;
                        count_d = down ? limit : '0;
                    end
                end
            end
            S_COUNT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    if (!dn_q) begin
                        if (up_hit) begin
                            count_d = lim_q;
                            state_d = S_DONE;
                        end else begin
                            count_d = up_sum[WIDTH-1:0];
                        end
                    end else begin
                        if (dn_hit) begin
                            count_d = '0;
                            state_d = S_DONE;
                        end else begin
                            count_d = count - STEP_X[WIDTH-1:0];
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            count   <= '0;
            lim_q   <= '0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            lim_q   <= lim_d;
            dn_q    <= dn_d;
        end
    end

    assign done = (state_q == S_DONE);
    assign busy = (state_q == S_COUNT);

endmodule

// File: tb/tb_hlsm_counter_gen.sv
// Directed bench for hlsm_counter_gen: three instances (STEP 1, 3, 4) share stimulus; each test checks one instance.
// Pause scenarios are compiled in only when HLSM_PAUSE_EN is defined.
module tb_hlsm_counter_gen;

    logic       Clk;
    logic       Rst;
    logic       go;
    logic [4:0] limit;
    logic       down;
    logic       abort;
`ifdef HLSM_PAUSE_EN
    logic       pause;
`endif
    logic [4:0] c1, c3, c4;
    logic       d1, d3, d4, b1, b3, b4;

    int checks = 0;
    int errors = 0;

    hlsm_counter_gen #(.WIDTH(5), .STEP(1)) u_s1 (
        .Clk(Clk), .Rst(Rst), .go(go), .limit(limit), .down(down), .abort(abort),
`ifdef HLSM_PAUSE_EN
        .pause(pause),
`endif
        .count(c1), .done(d1), .busy(b1)
    );

    hlsm_counter_gen #(.WIDTH(5), .STEP(3)) u_s3 (
        .Clk(Clk), .Rst(Rst), .go(go), .limit(limit), .down(down), .abort(abort),
`ifdef HLSM_PAUSE_EN
        .pause(pause),
`endif
        .count(c3), .done(d3), .busy(b3)
    );

    hlsm_counter_gen #(.WIDTH(5), .STEP(4)) u_s4 (
        .Clk(Clk), .Rst(Rst), .go(go), .limit(limit), .down(down), .abort(abort),
`ifdef HLSM_PAUSE_EN
        .pause(pause),
`endif
        .count(c4), .done(d4), .busy(b4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic start(input logic [4:0] lim, input logic dn);
        limit = lim;
        down  = dn;
        go    = 1'b1;
        tick();
        go    = 1'b0;
    endtask

    task automatic settle;
        for (int i = 0; i < 80; i++) begin
            if (!(b1 | b3 | b4 | d1 | d3 | d4)) break;
            tick();
        end
        checks++;
        if (b1 | b3 | b4 | d1 | d3 | d4) begin
            errors++;
            $display("FAIL settle_timeout busy=%b%b%b done=%b%b%b exp all 0", b1, b3, b4, d1, d3, d4);
        end
        tick();
    endtask

    task automatic test_reset;
        Rst = 1'b1; go = 1'b0; limit = '0; down = 1'b0; abort = 1'b0;
`ifdef HLSM_PAUSE_EN
        pause = 1'b0;
`endif
        #1 Rst = 1'b0;
        #2;
        checks++;
        if ({c1, d1, b1, c3, d3, b3, c4, d4, b4} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got c=%0d/%0d/%0d d=%b%b%b b=%b%b%b exp 0", c1, c3, c4, d1, d3, d4, b1, b3, b4);
        end
        @(negedge Clk);
        Rst = 1'b1;
        tick();
        checks++;
        if ({c1, d1, b1} !== 7'd0) begin
            errors++;
            $display("FAIL reset_idle got c=%0d d=%b b=%b exp 0/0/0", c1, d1, b1);
        end
    endtask

    task automatic test_up_count;
        start(5'd20, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            checks++;
            if (c1 !== 5'(k) || b1 !== (k < 20) || d1 !== (k == 20)) begin
                errors++;
                $display("FAIL up_count edge %0d got c=%0d b=%b d=%b exp c=%0d b=%b d=%b",
                         k, c1, b1, d1, k, (k < 20), (k == 20));
            end
        end
        tick();
        checks++;
        if (c1 !== 5'd20 || d1 !== 1'b0 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL up_after_done got c=%0d d=%b b=%b exp c=20 d=0 b=0", c1, d1, b1);
        end
        settle();
    endtask

    task automatic test_down_step3;
        logic [4:0] exp_c [5] = '{5'd10, 5'd7, 5'd4, 5'd1, 5'd0};
        start(5'd10, 1'b1);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            checks++;
            if (c3 !== exp_c[k] || b3 !== (k < 4) || d3 !== (k == 4)) begin
                errors++;
                $display("FAIL down_step3 edge %0d got c=%0d b=%b d=%b exp c=%0d b=%b d=%b",
                         k, c3, b3, d3, exp_c[k], (k < 4), (k == 4));
            end
        end
        tick();
        checks++;
        if (c3 !== 5'd0 || d3 !== 1'b0 || b3 !== 1'b0) begin
            errors++;
            $display("FAIL down_after_done got c=%0d d=%b b=%b exp c=0 d=0 b=0", c3, d3, b3);
        end
        settle();
    endtask

    task automatic test_saturate;
        int ndone = 0;
        logic [4:0] exp_c;
        start(5'd31, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            exp_c = (k == 8) ? 5'd31 : 5'(4 * k);
            ndone += int'(d4);
            checks++;
            if (c4 !== exp_c) begin
                errors++;
                $display("FAIL saturate edge %0d got c=%0d exp c=%0d", k, c4, exp_c);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            ndone += int'(d4);
        end
        checks++;
        if (c4 !== 5'd31 || ndone != 1) begin
            errors++;
            $display("FAIL saturate_end got c=%0d dones=%0d exp c=31 dones=1", c4, ndone);
        end
        settle();
    endtask

    task automatic test_abort;
        int ndone = 0;
        start(5'd20, 1'b0);
        for (int k = 1; k <= 6; k++) tick();
        checks++;
        if (c1 !== 5'd6 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got c=%0d b=%b exp c=6 b=1", c1, b1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ndone += int'(d1);
        checks++;
        if (c1 !== 5'd6 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_edge got c=%0d b=%b exp c=6 b=0", c1, b1);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            ndone += int'(d1);
        end
        checks++;
        if (c1 !== 5'd6 || ndone != 0) begin
            errors++;
            $display("FAIL abort_after got c=%0d dones=%0d exp c=6 dones=0", c1, ndone);
        end
        settle();
    endtask

    task automatic test_zero_limit;
        start(5'd0, 1'b0);
        checks++;
        if (d1 !== 1'b1 || b1 !== 1'b0 || c1 !== 5'd0) begin
            errors++;
            $display("FAIL zero_limit_done got c=%0d d=%b b=%b exp c=0 d=1 b=0", c1, d1, b1);
        end
        tick();
        checks++;
        if (d1 !== 1'b0 || c1 !== 5'd0) begin
            errors++;
            $display("FAIL zero_limit_after got c=%0d d=%b exp c=0 d=0", c1, d1);
        end
        settle();
    endtask

    task automatic test_go_ignored;
        start(5'd5, 1'b0);
        tick();
        tick();
        limit = 5'd3;
        down  = 1'b1;
        go    = 1'b1;
        tick();
        go    = 1'b0;
        checks++;
        if (c1 !== 5'd3 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL go_in_count got c=%0d b=%b exp c=3 b=1", c1, b1);
        end
        tick();
        tick();
        checks++;
        if (c1 !== 5'd5 || d1 !== 1'b1) begin
            errors++;
            $display("FAIL go_run_end got c=%0d d=%b exp c=5 d=1", c1, d1);
        end
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (c1 !== 5'd5 || b1 !== 1'b0 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL go_in_done got c=%0d b=%b d=%b exp c=5 b=0 d=0", c1, b1, d1);
        end
        tick();
        checks++;
        if (c1 !== 5'd5 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL go_in_done_after got c=%0d b=%b exp c=5 b=0", c1, b1);
        end
        settle();
    endtask

    task automatic test_async_reset;
        int seen = 0;
        start(5'd20, 1'b0);
        for (int k = 1; k <= 9; k++) tick();
        checks++;
        if (c1 !== 5'd9) begin
            errors++;
            $display("FAIL areset_pre got c=%0d exp c=9", c1);
        end
        #2 Rst = 1'b0;
        #1;
        checks++;
        if (c1 !== 5'd0 || b1 !== 1'b0 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate got c=%0d b=%b d=%b exp 0/0/0", c1, b1, d1);
        end
        @(negedge Clk);
        Rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            seen += int'(d1 | b1);
        end
        checks++;
        if (seen != 0 || c1 !== 5'd0) begin
            errors++;
            $display("FAIL areset_after got active_cycles=%0d c=%0d exp 0 and c=0", seen, c1);
        end
    endtask

`ifdef HLSM_PAUSE_EN
    task automatic test_pause;
        start(5'd8, 1'b0);
        for (int k = 1; k <= 5; k++) tick();
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (c1 !== 5'd5 || b1 !== 1'b1) begin
                errors++;
                $display("FAIL pause_hold %0d got c=%0d b=%b exp c=5 b=1", k, c1, b1);
            end
        end
        pause = 1'b0;
        for (int k = 6; k <= 8; k++) begin
            tick();
            checks++;
            if (c1 !== 5'(k) || d1 !== (k == 8)) begin
                errors++;
                $display("FAIL pause_resume got c=%0d d=%b exp c=%0d d=%b", c1, d1, k, (k == 8));
            end
        end
        settle();
        start(5'd8, 1'b0);
        tick();
        tick();
        pause = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pause = 1'b0;
        checks++;
        if (c1 !== 5'd2 || b1 !== 1'b0 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL pause_abort got c=%0d b=%b d=%b exp c=2 b=0 d=0", c1, b1, d1);
        end
        settle();
    endtask
`endif

    initial begin
        test_reset();
        test_up_count();
        test_down_step3();
        test_saturate();
        test_abort();
        test_zero_limit();
        test_go_ignored();
`ifdef HLSM_PAUSE_EN
        test_pause();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hlsm_counter_gen.md
# hlsm_counter_gen

Parametrised high-level state machine counter, successor to the fixed 5-bit go/count/done HLSM. A single `go` pulse starts a run that counts up from zero or down from a runtime limit, in steps of `STEP`. The block signals completion with a one-cycle `done`, and the count can be aborted early. It sits beside other lab-level controllers as a reusable sequencing and timing element.

## Interface
- `WIDTH`, 5: counter and limit width in bits; must be ≥2.
- `STEP`, 1: increment/decrement per cycle; 1 ≤ STEP ≤ 2^WIDTH−1.
- `Clk` in 1: clock; all state changes on its rising edge.
- `Rst` in 1: reset, **asynchronous, active-low**. `Rst`=0 forces the reset state immediately.
- `go` in 1: start request; sampled only in IDLE.
- `limit` in WIDTH: terminal value. Up mode counts to it; down mode counts from it. Captured on the accepted `go`.
- `down` in 1: mode, 0=up, 1=down; captured on the accepted `go`.
- `abort` in 1: synchronous cancel of a run in progress.
- `pause` in 1: hold the count. Present only with `HLSM_PAUSE_EN`.
- `count` out WIDTH: current count, registered.
- `done` out 1: high for exactly one cycle when a run completes.
- `busy` out 1: high while in COUNT.

## Operation
- States: IDLE, COUNT, DONE. Encoding is free.
- Outputs are Moore-style: `done` = (state==DONE), `busy` = (state==COUNT).
- Reset: state=IDLE, `count`=0, `done`=0, `busy`=0, and the captured limit and mode registers are 0.
- IDLE:
  - On `go`=1, capture `limit` into lim_q and `down` into dn_q.
  - If `limit`==0: go to DONE with `count`=0.
  - Otherwise go to COUNT with `count` = dn_q ? `limit` : 0.
  - With `go`=0: `count` holds its last value.
- COUNT, evaluated in priority order:
  1. `abort`=1 → IDLE. `count` holds, no `done`.
  2. (`HLSM_PAUSE_EN`) `pause`=1 → hold state and `count`.
  3. Up mode: if `count`+STEP ≥ lim_q, set `count`=lim_q (saturate, never overshoot) and go to DONE. Otherwise `count`+=STEP.
  4. Down mode: if `count` ≤ STEP, set `count`=0 and go to DONE. Otherwise `count`−=STEP.
- DONE: unconditionally → IDLE next cycle. `count` holds the terminal value (lim_q for up, 0 for down).
- Arithmetic: the up-mode sum is computed in WIDTH+1 bits, so `count` never wraps, including when lim_q = 2^WIDTH−1.
- `go` outside IDLE is ignored, including `go` during DONE. A new run needs `go` in an IDLE cycle.
- `abort` in IDLE or DONE has no effect.
- `limit` and `down` changes after capture have no effect on the current run.

## Timing
- Edge 0 is the edge that samples `go` in IDLE. At edge 0, `count` loads and state becomes COUNT.
- Up mode, STEP=1, limit L≥1: `count` = k after edge k. State becomes DONE at edge L. `done` is high from edge L to edge L+1, with `busy` low in that cycle. State is IDLE again from edge L+1.
- General terminal edge:
  - Up mode: ceil(L/STEP).
  - Down mode: ceil(L/STEP).
  - The `done` cycle always follows that edge immediately.
- `limit`=0: DONE at edge 0, `done` high for the following cycle only.
- Earliest next accepted `go`: edge L+2 (first IDLE sample).
- Reset mid-run: all outputs take their reset values asynchronously on `Rst` falling, and state is IDLE on the first edge with `Rst`=1. No `done` is produced.
- `abort` sampled at edge k during COUNT: IDLE from edge k, `busy` low after edge k, `count` equals its value before edge k.

## Configuration
- `HLSM_PAUSE_EN` defined:
  - `pause` port exists.
  - `pause`=1 in COUNT freezes `count` and state. Each paused cycle extends the terminal edge by one.
  - `abort` overrides `pause`.
  - `pause` is ignored in IDLE and DONE.
- `HLSM_PAUSE_EN` undefined: no `pause` port; COUNT advances every cycle unless aborted.

## Test plan
- Reset then up count, WIDTH=5, STEP=1: assert `Rst`=0, release, then pulse `go` one cycle with `limit`=20, `down`=0 → `count` 0..20 at edges 0..20. `done`=1 only in the cycle after edge 20, then IDLE with `count`=20. `busy`=1 across edges 0..19.
- Down count, STEP=3: `limit`=10, `down`=1 → `count` 10,7,4,1,0. `done` in the cycle after the 0 load. Never negative or wrapped.
- Saturation, WIDTH=5, STEP=4: up with `limit`=31 → `count` 0,4,…,28,31. No wrap to 0; a single `done`.
- Abort plus edge cases:
  - `abort` at `count`=6 of a `limit`=20 run → IDLE, `count`=6, no `done`.
  - `go` with `limit`=0 → `done` one cycle after the go edge, `count`=0.
  - `go` during COUNT or DONE → ignored.
- Async reset mid-run: drop `Rst` between clock edges at `count`=9 → `count`=0, `busy`=0, `done`=0 immediately. No `done` after release.
- (`HLSM_PAUSE_EN`) `pause` high for 3 cycles at `count`=5, `limit`=8 → `count` holds at 5 for 3 cycles, and `done` arrives 3 cycles later than the unpaused run. `abort` during `pause` → IDLE.
